// File: rtl/alu_unit_if.sv
// Operand/result bundle for the 32-bit ALU.
//   a, b   : operands (two's complement), driven by the master
//   inst   : 4-bit opcode, driven by the master
//   z      : result, driven by the slave (the ALU)
//   flags  : [0]=overflow [1]=carry [2]=zero [3]=reserved (always 0)
interface alu_unit_if;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  inst;
    logic [31:0] z;
    logic [3:0]  flags;

    modport master (
        output a,
        output b,
        output inst,
        input  z,
        input  flags
    );

    modport slave (
        input  a,
        input  b,
        input  inst,
        output z,
        output flags
    );
endinterface

// File: rtl/alu_unit.sv
// 32-bit integer ALU: 15 arithmetic/logic ops selected by a 4-bit opcode,
// plus overflow, carry and zero flags.
// Operands and opcode are registered every clock. The result and flags are
// combinational from those registers, so they are valid one cycle after the
// inputs are applied.
// Ports:
//   clk    : clock, rising edge active
//   rst_n  : asynchronous active-low reset
//   bus    : alu_unit_if.slave (a, b, inst in; z, flags out)
module alu_unit (
    input  logic       clk,
    input  logic       rst_n,
    alu_unit_if.slave  bus
);
    localparam int DATA_W = 32;

    logic signed [DATA_W-1:0] a_p0;
    logic signed [DATA_W-1:0] b_p0;
    logic [3:0]               op_p0;

    // ---- stage p0: operand/opcode capture ----
    // Reset opcode E (constant zero) so the outputs read Z=0 with ZERO set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_p0  <= '0;
            b_p0  <= '0;
            op_p0 <= 4'hE;
        end else begin
            a_p0  <= bus.a;
            b_p0  <= bus.b;
            op_p0 <= bus.inst;
        end
    end

    // ---- combinational result from stage p0 ----
    logic [DATA_W-1:0] add_x;
    logic [DATA_W-1:0] add_y;
    logic              add_cin;
    logic              is_arith;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] a_u;
    logic [DATA_W-1:0] b_u;
    logic [DATA_W-1:0] z_c;
    logic              ovf;
    logic              carry;

    assign a_u = $unsigned(a_p0);
    assign b_u = $unsigned(b_p0);

    // Every arithmetic op shares one adder: sum = X + Y + cin.
    // Subtraction and negation use the inverted operand with cin=1.
    always_comb begin
        add_x    = '0;
        add_y    = '0;
        add_cin  = 1'b0;
        is_arith = 1'b0;
        unique case (op_p0)
            4'h0: begin add_x = a_u; add_y = '0;   add_cin = 1'b1; is_arith = 1'b1; end
            4'h1: begin add_x = a_u; add_y = '1;   add_cin = 1'b0; is_arith = 1'b1; end
            4'h2: begin add_x = a_u; add_y = b_u;  add_cin = 1'b0; is_arith = 1'b1; end
            4'h3: begin add_x = a_u; add_y = ~b_u; add_cin = 1'b1; is_arith = 1'b1; end
            // abs: negative operands take the negate path, others pass through
            4'h4: begin
                if (a_u[DATA_W-1]) begin
                    add_x = '0; add_y = ~a_u; add_cin = 1'b1; is_arith = 1'b1;
                end
            end
            4'h5: begin add_x = '0;  add_y = ~a_u; add_cin = 1'b1; is_arith = 1'b1; end
            4'h7: begin add_x = '0;  add_y = ~b_u; add_cin = 1'b1; is_arith = 1'b1; end
            default: ;
        endcase
    end

    assign sum = {1'b0, add_x} + {1'b0, add_y} + {{DATA_W{1'b0}}, add_cin};

    always_comb begin
        z_c = '0;
        if (is_arith) begin
            z_c = sum[DATA_W-1:0];
        end else begin
            unique case (op_p0)
                4'h4:    z_c = a_u;          // abs of a non-negative value
                4'h8:    z_c = a_u & b_u;
                4'h9:    z_c = a_u | b_u;
                4'hA:    z_c = a_u ^ b_u;
                4'hB:    z_c = ~b_u;
                4'hC:    z_c = a_u;
                4'hD:    z_c = ~a_u;
                4'hF:    z_c = '1;
                default: z_c = '0;           // 6 (unsupported) and E
            endcase
        end
    end

    // Signed overflow: both adder inputs share a sign that the result lacks.
    // For subtract, carry=1 means no borrow.
    assign carry = is_arith & sum[DATA_W];
    assign ovf   = is_arith & (add_x[DATA_W-1] == add_y[DATA_W-1])
                            & (z_c[DATA_W-1] != add_x[DATA_W-1]);

    assign bus.z     = z_c;
    assign bus.flags = {1'b0, (z_c == '0), carry, ovf};
endmodule

// File: tb/tb_alu_unit.sv
// Directed and random checks for alu_unit.
module tb_alu_unit;
    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    alu_unit_if bus ();

    alu_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Independent reference: results via native 32-bit arithmetic, flags
    // from unsigned/signed range reasoning rather than the adder form.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] op,
                                  output logic [31:0] z, output logic [3:0] f);
        longint sa, sb, r;
        logic c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c = 1'b0; v = 1'b0; z = '0;
        case (op)
            4'h0: begin z = a + 1; c = (a == 32'hFFFFFFFF); v = (a == 32'h7FFFFFFF); end
            4'h1: begin z = a - 1; c = (a != 0);            v = (a == 32'h80000000); end
            4'h2: begin
                z = a + b; r = sa + sb;
                c = (({32'd0, a} + {32'd0, b}) > 64'hFFFFFFFF);
                v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            4'h3: begin
                z = a - b; r = sa - sb;
                c = (a >= b);
                v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            4'h4: begin
                if (a[31]) begin z = -a; v = (a == 32'h80000000); end
                else z = a;
            end
            4'h5: begin z = -a; c = (a == 0); v = (a == 32'h80000000); end
            4'h7: begin z = -b; c = (b == 0); v = (b == 32'h80000000); end
            4'h8: z = a & b;
            4'h9: z = a | b;
            4'hA: z = a ^ b;
            4'hB: z = ~b;
            4'hC: z = a;
            4'hD: z = ~a;
            4'hF: z = 32'hFFFFFFFF;
            default: z = '0;
        endcase
        f = {1'b0, (z == 0), c, v};
    endfunction

    task automatic vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [31:0] ez, input logic [3:0] ef);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.inst = op;
        @(posedge clk);
        #1;
        check({tag, ".z"}, bus.z, ez);
        check({tag, ".flags"}, {28'd0, bus.flags}, {28'd0, ef});
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] sp [5];
        sp[0] = 32'h0; sp[1] = 32'h1; sp[2] = 32'h7FFFFFFF;
        sp[3] = 32'h80000000; sp[4] = 32'hFFFFFFFF;
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        logic [31:0] ra, rb, mz;
        logic [3:0]  rop, mf;
        n_total = 0;
        n_bad   = 0;
        rst_n    = 1'b0;
        bus.a    = 32'h12345678;
        bus.b    = 32'h9ABCDEF0;
        bus.inst = 4'hF;
        #12;
        check("reset.z", bus.z, 32'h0);
        check("reset.flags", {28'd0, bus.flags}, 32'h4);
        @(negedge clk);
        rst_n = 1'b1;

        vec("inc5",     32'h5,        32'h0,        4'h0, 32'h6,        4'b0000);
        vec("inc_wrap", 32'hFFFFFFFF, 32'h0,        4'h0, 32'h0,        4'b0110);
        vec("add_ovf",  32'h7FFFFFFF, 32'h1,        4'h2, 32'h80000000, 4'b0001);
        vec("sub_eq",   32'h5,        32'h5,        4'h3, 32'h0,        4'b0110);
        vec("sub_neg",  32'h3,        32'h5,        4'h3, 32'hFFFFFFFE, 4'b0000);
        vec("dec0",     32'h0,        32'h0,        4'h1, 32'hFFFFFFFF, 4'b0000);
        vec("dec_min",  32'h80000000, 32'h0,        4'h1, 32'h7FFFFFFF, 4'b0011);
        vec("abs_neg",  32'hFFFFFFF6, 32'h0,        4'h4, 32'h0000000A, 4'b0000);
        vec("abs_min",  32'h80000000, 32'h0,        4'h4, 32'h80000000, 4'b0001);
        vec("abs_pos",  32'h5,        32'h0,        4'h4, 32'h5,        4'b0000);
        vec("neg0",     32'h0,        32'h0,        4'h5, 32'h0,        4'b0110);
        vec("neg_min",  32'h80000000, 32'h0,        4'h5, 32'h80000000, 4'b0001);
        vec("negb1",    32'h0,        32'h1,        4'h7, 32'hFFFFFFFF, 4'b0000);
        vec("and",   32'hF0F0F0F0, 32'hFF00FF00, 4'h8, 32'hF000F000, 4'b0000);
        vec("or",    32'hF0F0F0F0, 32'hFF00FF00, 4'h9, 32'hFFF0FFF0, 4'b0000);
        vec("xor",   32'hF0F0F0F0, 32'hFF00FF00, 4'hA, 32'h0FF00FF0, 4'b0000);
        vec("notb",  32'hF0F0F0F0, 32'hFF00FF00, 4'hB, 32'h00FF00FF, 4'b0000);
        vec("pass",  32'hF0F0F0F0, 32'hFF00FF00, 4'hC, 32'hF0F0F0F0, 4'b0000);
        vec("nota",  32'hF0F0F0F0, 32'hFF00FF00, 4'hD, 32'h0F0F0F0F, 4'b0000);
        vec("zero",  32'hF0F0F0F0, 32'hFF00FF00, 4'hE, 32'h0,        4'b0100);
        vec("ones",  32'hF0F0F0F0, 32'hFF00FF00, 4'hF, 32'hFFFFFFFF, 4'b0000);
        vec("unsup", 32'hF0F0F0F0, 32'hFF00FF00, 4'h6, 32'h0,        4'b0100);

        // Asynchronous reset between edges must clear the in-flight result at once.
        vec("pre_rst", 32'h1, 32'h2, 4'h2, 32'h3, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.z", bus.z, 32'h0);
        check("async_rst.flags", {28'd0, bus.flags}, 32'h4);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 320; i++) begin
            ra  = pick();
            rb  = pick();
            rop = 4'(i % 16);
            @(negedge clk);
            bus.a = ra; bus.b = rb; bus.inst = rop;
            @(posedge clk);
            #1;
            model(ra, rb, rop, mz, mf);
            check($sformatf("rnd%0d.op%h.z", i, rop), bus.z, mz);
            check($sformatf("rnd%0d.op%h.flags", i, rop), {28'd0, bus.flags}, {28'd0, mf});
            check($sformatf("rnd%0d.zero", i), {31'd0, bus.flags[2]}, {31'd0, ~|bus.z});
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
